frame_capture_ctrl: RTL and testbench

Sequences the shared single-frame boolean image memory between the pixel packer (write side) and two frame consumers (read side). On request it arms, waits for a frame boundary, and admits exactly one full frame of packed writes. It then freezes the memory and round-robin arbitrates its read port between two requesters until the frame is released. It sits between the brightness-threshold packer and `image_memory`, and between `image_memory` and the downstream analysis and overlay engines.

---
 rtl/frame_capture_ctrl_if.sv | 46 ++++
 rtl/frame_capture_ctrl.sv | 171 +++++++++++++++++
 tb/tb_frame_capture_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_capture_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : frame_capture_ctrl_if
//  Purpose  : Bundles the packer write port, the image_memory ports and the
//             two-requester read port of frame_capture_ctrl.
//  Signals  : cap_wren/cap_addr/cap_data     packer -> controller
//             mem_wren/mem_wraddress/mem_data controller -> memory write port
//             mem_rdaddress / mem_q           memory read port
//             req/addr0/addr1 -> gnt/rvalid/rdata  read requesters
//  Modports : slave  - the controller
//             master - the environment (packer, memory, consumers)
//  Revision : 1.0  initial release
// ============================================================================
interface frame_capture_ctrl_if #(
   parameter int ADDR_W = 16
);
   // packer write side
   logic              cap_wren;
   logic [ADDR_W-1:0] cap_addr;
   logic [7:0]        cap_data;
   // image_memory ports
   logic              mem_wren;
   logic [ADDR_W-1:0] mem_wraddress;
   logic [7:0]        mem_data;
   logic [ADDR_W-1:0] mem_rdaddress;
   logic [7:0]        mem_q;
   // read requesters
   logic [1:0]        req;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [1:0]        gnt;
   logic [1:0]        rvalid;
   logic [7:0]        rdata;

   modport slave (
      input  cap_wren, cap_addr, cap_data, mem_q, req, addr0, addr1,
      output mem_wren, mem_wraddress, mem_data, mem_rdaddress, gnt, rvalid, rdata
   );

   modport master (
      output cap_wren, cap_addr, cap_data, mem_q, req, addr0, addr1,
      input  mem_wren, mem_wraddress, mem_data, mem_rdaddress, gnt, rvalid, rdata
   );
endinterface
`default_nettype wire

// File: rtl/frame_capture_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : frame_capture_ctrl
//  Purpose  : Owns the single-frame boolean image memory. On request it arms,
//             waits for a vertical-sync falling edge, admits exactly one frame
//             of packed writes, then freezes the memory and round-robin
//             arbitrates its read port between two consumers until released.
//  Ports    : VGA_CLK        pixel clock (only clock)
//             reset_n        synchronous active-low reset
//             iVGA_VS        vertical sync, low between frames
//             start          capture request pulse (honoured in IDLE only)
//             continuous     release re-arms capture when set
//             release_frame  consumers are done with the frame
//             bus            packer / memory / requester signals (slave)
//             frame_ready    frame frozen and readable
//             busy           armed or capturing
//             frame_count    completed captures, wraps at 256
//             addr_err       sticky out-of-range write flag
//  Revision : 1.0  initial release
// ============================================================================
module frame_capture_ctrl #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int ADDR_W = 16,
   parameter int RD_LAT = 2
) (
   input  wire                      VGA_CLK,
   input  wire                      reset_n,
   input  wire                      iVGA_VS,
   input  wire                      start,
   input  wire                      continuous,
   input  wire                      release_frame,
   frame_capture_ctrl_if.slave      bus,
   output logic                     frame_ready,
   output logic                     busy,
   output logic [7:0]               frame_count,
   output logic                     addr_err
);

   // Number of packed words in one frame; compared one bit wider so a frame
   // that fills the whole address space still has a representable limit.
   localparam int unsigned     C_WORDS     = (WIDTH * HEIGHT) / 8;
   localparam logic [ADDR_W:0] C_WORDS_LIM = (ADDR_W+1)'(C_WORDS);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARM     = 2'd1,
      S_CAPTURE = 2'd2,
      S_READY   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              vs_prev_q;
   logic              frame_ready_q;
   logic              busy_q;
   logic [7:0]        frame_count_q;
   logic              addr_err_q;
   logic              mem_wren_q;
   logic [ADDR_W-1:0] mem_wraddress_q;
   logic [7:0]        mem_data_q;
   logic [ADDR_W-1:0] mem_rdaddress_q;
   logic              rr_ptr_q;          // 0: requester 0 has priority
   logic [1:0]        rv_pipe_q [RD_LAT];

   logic              vs_fall;
   logic              in_range;
   logic              wr_ok;
   logic              wr_bad;
   logic              rd_en;
   logic [1:0]        gnt_c;

   assign vs_fall  = vs_prev_q & ~iVGA_VS;
   assign in_range = ({1'b0, bus.cap_addr} < C_WORDS_LIM);
   assign wr_ok    = bus.cap_wren & (state_q == S_CAPTURE) & in_range;
   assign wr_bad   = bus.cap_wren & (state_q == S_CAPTURE) & ~in_range;

   // A release in the same cycle as a request takes precedence, so no new
   // read is started against a frame that is being handed back.
   assign rd_en = reset_n & (state_q == S_READY) & ~release_frame;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start)         state_d = S_ARM;
         S_ARM:     if (vs_fall)       state_d = S_CAPTURE;
         S_CAPTURE: if (vs_fall)       state_d = S_READY;
         S_READY:   if (release_frame) state_d = continuous ? S_ARM : S_IDLE;
         default:                      state_d = S_IDLE;
      endcase
   end

   // Round-robin: a lone requester always wins; on contention the pointer
   // decides, and it then swings to the requester that was not served.
   always_comb begin
      gnt_c = 2'b00;
      if (rd_en) begin
         case (bus.req)
            2'b01:   gnt_c = 2'b01;
            2'b10:   gnt_c = 2'b10;
            2'b11:   gnt_c = rr_ptr_q ? 2'b10 : 2'b01;
            default: gnt_c = 2'b00;
         endcase
      end
   end

   always_ff @(posedge VGA_CLK) begin
      if (!reset_n) begin
         state_q         <= S_IDLE;
         vs_prev_q       <= 1'b0;
         frame_ready_q   <= 1'b0;
         busy_q          <= 1'b0;
         frame_count_q   <= 8'd0;
         addr_err_q      <= 1'b0;
         mem_wren_q      <= 1'b0;
         mem_wraddress_q <= '0;
         mem_data_q      <= 8'd0;
         mem_rdaddress_q <= '0;
         rr_ptr_q        <= 1'b0;
         for (int i = 0; i < RD_LAT; i++) begin
            rv_pipe_q[i] <= 2'b00;
         end
      end else begin
         state_q       <= state_d;
         vs_prev_q     <= iVGA_VS;
         // Status flags follow the state being entered, so they line up
         // with the state register rather than lagging it.
         frame_ready_q <= (state_d == S_READY);
         busy_q        <= (state_d == S_ARM) || (state_d == S_CAPTURE);

         if ((state_q == S_CAPTURE) && vs_fall) begin
            frame_count_q <= frame_count_q + 8'd1;
         end

         mem_wren_q <= wr_ok;
         if (wr_ok) begin
            mem_wraddress_q <= bus.cap_addr;
            mem_data_q      <= bus.cap_data;
         end
         if (wr_bad) begin
            addr_err_q <= 1'b1;
         end

         if (gnt_c != 2'b00) begin
            mem_rdaddress_q <= gnt_c[1] ? bus.addr1 : bus.addr0;
            rr_ptr_q        <= gnt_c[0];
         end

         // The granted one-hot travels alongside the memory read latency.
         rv_pipe_q[0] <= gnt_c;
         for (int i = 1; i < RD_LAT; i++) begin
            rv_pipe_q[i] <= rv_pipe_q[i-1];
         end
      end
   end

   assign bus.mem_wren      = mem_wren_q;
   assign bus.mem_wraddress = mem_wraddress_q;
   assign bus.mem_data      = mem_data_q;
   assign bus.mem_rdaddress = mem_rdaddress_q;
   assign bus.gnt           = gnt_c;
   assign bus.rvalid        = rv_pipe_q[RD_LAT-1];
   assign bus.rdata         = bus.mem_q;

   assign frame_ready = frame_ready_q;
   assign busy        = busy_q;
   assign frame_count = frame_count_q;
   assign addr_err    = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_capture_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_frame_capture_ctrl
//  Purpose  : Directed bench for frame_capture_ctrl with write and read
//             scoreboards and a behavioural image_memory (2-cycle read).
//  Revision : 1.0  initial release
// ============================================================================
module tb_frame_capture_ctrl;

   localparam int ADDR_W = 16;
   localparam int WORDS  = 640 * 480 / 8;

   logic       VGA_CLK       = 1'b0;
   logic       reset_n       = 1'b0;
   logic       iVGA_VS       = 1'b1;
   logic       start         = 1'b0;
   logic       continuous    = 1'b0;
   logic       release_frame = 1'b0;
   logic       frame_ready;
   logic       busy;
   logic [7:0] frame_count;
   logic       addr_err;

   frame_capture_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   frame_capture_ctrl #(
      .WIDTH (640),
      .HEIGHT(480),
      .ADDR_W(ADDR_W),
      .RD_LAT(2)
   ) dut (
      .VGA_CLK      (VGA_CLK),
      .reset_n      (reset_n),
      .iVGA_VS      (iVGA_VS),
      .start        (start),
      .continuous   (continuous),
      .release_frame(release_frame),
      .bus          (bus),
      .frame_ready  (frame_ready),
      .busy         (busy),
      .frame_count  (frame_count),
      .addr_err     (addr_err)
   );

   always #5 VGA_CLK = ~VGA_CLK;

   int checks    = 0;
   int errors    = 0;
   int cyc       = 0;
   int wr_pulses = 0;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   typedef struct {
      int          due;
      logic [1:0]  who;
      logic [7:0]  data;
   } rd_t;

   wr_t wr_q[$];
   rd_t rd_q[$];

   logic [7:0] mem [0:65535];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge VGA_CLK);
      #1;
   endtask

   function automatic logic [7:0] pat(input int a);
      return 8'(a) ^ 8'h5A;
   endfunction

   always @(posedge VGA_CLK) cyc = cyc + 1;

   // behavioural image_memory: registered read on top of the registered address
   always @(posedge VGA_CLK) begin
      if (bus.mem_wren === 1'b1) mem[bus.mem_wraddress] <= bus.mem_data;
      bus.mem_q <= mem[bus.mem_rdaddress];
   end

   // write scoreboard
   always @(negedge VGA_CLK) begin
      wr_t e;
      if (bus.mem_wren === 1'b1) begin
         wr_pulses++;
         if (wr_q.size() == 0) begin
            chk("wr_unexpected_wren", 32'(bus.mem_wren), 32'd0);
         end else begin
            e = wr_q.pop_front();
            chk("wr_addr", 32'(bus.mem_wraddress), 32'(e.addr));
            chk("wr_data", 32'(bus.mem_data), 32'(e.data));
         end
      end
   end

   // read scoreboard
   always @(negedge VGA_CLK) begin
      rd_t e;
      while (rd_q.size() > 0 && rd_q[0].due < cyc) begin
         e = rd_q.pop_front();
         chk("rvalid_missing", 32'(cyc), 32'(e.due));
      end
      if (bus.rvalid !== 2'b00) begin
         if (rd_q.size() == 0) begin
            chk("rvalid_unexpected", 32'(bus.rvalid), 32'd0);
         end else begin
            e = rd_q.pop_front();
            chk("rvalid_cycle", 32'(cyc), 32'(e.due));
            chk("rvalid_who", 32'(bus.rvalid), 32'(e.who));
            chk("rdata", 32'(bus.rdata), 32'(e.data));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // drive a read request, check the grant and queue the expected return
   task automatic rd_step(input string tag, input logic [1:0] r, input logic [1:0] g, input logic [15:0] a);
      bus.req = r;
      #1;
      chk(tag, 32'(bus.gnt), 32'(g));
      if (g != 2'b00) rd_q.push_back('{due: cyc + 2, who: g, data: pat(int'(a))});
      tick();
      if (g != 2'b00) chk({tag, "_rdaddress"}, 32'(bus.mem_rdaddress), 32'(a));
   endtask

   logic [1:0] exp_g [4];

   initial begin
      bus.cap_wren = 1'b0;
      bus.cap_addr = '0;
      bus.cap_data = 8'd0;
      bus.req      = 2'b00;
      bus.addr0    = '0;
      bus.addr1    = '0;

      // ---- reset state ----
      repeat (3) tick();
      chk("rst_mem_wren",      32'(bus.mem_wren),      32'd0);
      chk("rst_gnt",           32'(bus.gnt),           32'd0);
      chk("rst_rvalid",        32'(bus.rvalid),        32'd0);
      chk("rst_frame_ready",   32'(frame_ready),       32'd0);
      chk("rst_busy",          32'(busy),              32'd0);
      chk("rst_addr_err",      32'(addr_err),          32'd0);
      chk("rst_frame_count",   32'(frame_count),       32'd0);
      chk("rst_mem_wraddress", 32'(bus.mem_wraddress), 32'd0);
      chk("rst_mem_data",      32'(bus.mem_data),      32'd0);
      chk("rst_mem_rdaddress", 32'(bus.mem_rdaddress), 32'd0);
      reset_n = 1'b1;
      tick();

      // ---- writes blocked in IDLE ----
      bus.cap_wren = 1'b1; bus.cap_addr = 16'd3; bus.cap_data = 8'hAA;
      tick();
      bus.cap_wren = 1'b0;
      chk("idle_freeze_wren", 32'(bus.mem_wren), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      // ---- start -> ARM ----
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("arm_busy", 32'(busy), 32'd1);
      chk("arm_frame_ready", 32'(frame_ready), 32'd0);

      // ---- writes blocked in ARM; start ignored ----
      bus.cap_wren = 1'b1; bus.cap_addr = 16'd4; start = 1'b1;
      tick();
      bus.cap_wren = 1'b0; start = 1'b0;
      chk("arm_freeze_wren", 32'(bus.mem_wren), 32'd0);
      chk("arm_still_busy", 32'(busy), 32'd1);

      // ---- VS fall -> CAPTURE ----
      iVGA_VS = 1'b0;
      tick();
      iVGA_VS = 1'b1;
      chk("capture_busy", 32'(busy), 32'd1);

      // ---- full frame; last word lands in the ending vs_fall cycle ----
      for (int a = 0; a < WORDS; a++) begin
         if (a == 1000) begin
            bus.cap_wren = 1'b1; bus.cap_addr = 16'(WORDS); bus.cap_data = 8'hFF;
            tick();
            chk("oob_addr_err", 32'(addr_err), 32'd1);
            chk("oob_no_wren", 32'(bus.mem_wren), 32'd0);
         end
         bus.cap_wren = 1'b1;
         bus.cap_addr = 16'(a);
         bus.cap_data = pat(a);
         if (a == WORDS - 1) iVGA_VS = 1'b0;
         wr_q.push_back('{addr: 16'(a), data: pat(a)});
         tick();
         if (a == 5) chk("capture_busy_mid", 32'(busy), 32'd1);
      end
      bus.cap_wren = 1'b0;
      iVGA_VS = 1'b1;
      chk("ready_frame_ready", 32'(frame_ready), 32'd1);
      chk("ready_busy", 32'(busy), 32'd0);
      chk("ready_frame_count", 32'(frame_count), 32'd1);
      tick();
      chk("frame_wr_pulses", 32'(wr_pulses), 32'(WORDS));
      chk("frame_wr_queue_empty", 32'(wr_q.size()), 32'd0);

      // ---- writes blocked in READY ----
      bus.cap_wren = 1'b1; bus.cap_addr = 16'd7; bus.cap_data = 8'h00;
      tick();
      bus.cap_wren = 1'b0;
      chk("ready_freeze_wren", 32'(bus.mem_wren), 32'd0);
      chk("ready_addr_err_sticky", 32'(addr_err), 32'd1);

      // ---- round-robin with both requesters ----
      bus.addr0 = 16'd5; bus.addr1 = 16'd9;
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      for (int i = 0; i < 4; i++) begin
         rd_step("rr_gnt", 2'b11, exp_g[i], (exp_g[i] == 2'b01) ? 16'd5 : 16'd9);
      end
      bus.req = 2'b00;
      repeat (3) tick();

      // ---- lone requester granted every cycle ----
      rd_step("lone_gnt", 2'b10, 2'b10, 16'd9);
      rd_step("lone_gnt", 2'b10, 2'b10, 16'd9);
      bus.req = 2'b00;
      repeat (3) tick();

      // ---- release collides with a request ----
      rd_step("pre_collision_gnt", 2'b01, 2'b01, 16'd5);
      release_frame = 1'b1;
      rd_step("collision_gnt", 2'b01, 2'b00, 16'd0);
      release_frame = 1'b0;
      bus.req = 2'b00;
      chk("release_frame_ready", 32'(frame_ready), 32'd0);
      chk("release_idle_busy", 32'(busy), 32'd0);
      chk("release_addr_err_sticky", 32'(addr_err), 32'd1);
      repeat (3) tick();

      // ---- second capture, then continuous release -> ARM ----
      start = 1'b1;
      tick();
      start = 1'b0;
      iVGA_VS = 1'b0;
      tick();
      iVGA_VS = 1'b1;
      for (int a = 100; a < 104; a++) begin
         bus.cap_wren = 1'b1; bus.cap_addr = 16'(a); bus.cap_data = pat(a);
         wr_q.push_back('{addr: 16'(a), data: pat(a)});
         tick();
      end
      bus.cap_wren = 1'b0;
      iVGA_VS = 1'b0;
      tick();
      iVGA_VS = 1'b1;
      chk("second_frame_ready", 32'(frame_ready), 32'd1);
      chk("second_frame_count", 32'(frame_count), 32'd2);
      continuous = 1'b1;
      release_frame = 1'b1;
      rd_step("cont_collision_gnt", 2'b01, 2'b00, 16'd0);
      release_frame = 1'b0;
      continuous = 1'b0;
      bus.req = 2'b00;
      chk("cont_busy", 32'(busy), 32'd1);
      chk("cont_frame_ready", 32'(frame_ready), 32'd0);

      // ---- reset in the middle of a capture ----
      iVGA_VS = 1'b0;
      tick();
      iVGA_VS = 1'b1;
      chk("cap2_busy", 32'(busy), 32'd1);
      for (int a = 200; a < 202; a++) begin
         bus.cap_wren = 1'b1; bus.cap_addr = 16'(a); bus.cap_data = pat(a);
         wr_q.push_back('{addr: 16'(a), data: pat(a)});
         tick();
      end
      bus.cap_addr = 16'd202; bus.cap_data = pat(202);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("midrst_mem_wren",      32'(bus.mem_wren),      32'd0);
      chk("midrst_busy",          32'(busy),              32'd0);
      chk("midrst_frame_ready",   32'(frame_ready),       32'd0);
      chk("midrst_frame_count",   32'(frame_count),       32'd0);
      chk("midrst_addr_err",      32'(addr_err),          32'd0);
      chk("midrst_mem_wraddress", 32'(bus.mem_wraddress), 32'd0);
      chk("midrst_mem_data",      32'(bus.mem_data),      32'd0);
      chk("midrst_mem_rdaddress", 32'(bus.mem_rdaddress), 32'd0);
      chk("midrst_rvalid",        32'(bus.rvalid),        32'd0);
      for (int a = 203; a < 206; a++) begin
         bus.cap_addr = 16'(a);
         tick();
         chk("postrst_no_wren", 32'(bus.mem_wren), 32'd0);
         chk("postrst_busy", 32'(busy), 32'd0);
      end
      bus.cap_wren = 1'b0;
      repeat (3) tick();

      chk("end_wr_queue_empty", 32'(wr_q.size()), 32'd0);
      chk("end_rd_queue_empty", 32'(rd_q.size()), 32'd0);
      chk("end_wr_pulses", 32'(wr_pulses), 32'(WORDS + 4 + 2));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
